// File: rtl/jk_pkg.sv
// Shared state type, JK code points and the per-bit excitation rule for the
// JK bank driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] JK_CLR = 2'b01;
    localparam logic [1:0] JK_SET = 2'b10;
    localparam logic [1:0] JK_TGL = 2'b11;

    // {j,k} that moves one cell from s to t. JK=00 clears the cell, so a bit that
    // stays at 1 still needs SET.
    function automatic logic [1:0] jk_excite(input logic s, input logic t, input logic prefer_toggle);
        logic [1:0] code;
        code = JK_CLR;
        case ({s, t})
            2'b00:   code = JK_CLR;
            2'b01:   code = prefer_toggle ? JK_TGL : JK_SET;
            2'b11:   code = JK_SET;
            2'b10:   code = prefer_toggle ? JK_TGL : JK_CLR;
            default: code = JK_CLR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Combinational J/K excitation for a single cell of the bank.
module jk_excite_bit
    import jk_pkg::*;
#(
    parameter int PREFER_TOGGLE = 0
) (
    input  logic s,
    input  logic t,
    output logic j,
    output logic k
);

    logic [1:0] code_s;

    assign code_s = jk_excite(s, t, (PREFER_TOGGLE != 0));
    assign j      = code_s[1];
    assign k      = code_s[0];

endmodule

// File: rtl/jk_bank_driver.sv
// Write side of a JK register bank: turns accepted target words into one cycle of
// J/K excitation, then reads the bank back and tracks mismatches.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int PREFER_TOGGLE = 0,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tgt_valid,
    input  logic [WIDTH-1:0]     tgt_data,
    output logic                 tgt_ready,
    output logic [WIDTH-1:0]     j_out,
    output logic [WIDTH-1:0]     k_out,
    input  logic [WIDTH-1:0]     q_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1'b1);
    localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [WIDTH-1:0]       shadow_r;
    logic [WIDTH-1:0]       shadow_nxt_s;
    logic [WIDTH-1:0]       expected_r;
    logic [WIDTH-1:0]       expected_nxt_s;
    logic [WIDTH-1:0]       exc_j_s;
    logic [WIDTH-1:0]       exc_k_s;
    logic [WIDTH-1:0]       j_nxt_s;
    logic [WIDTH-1:0]       k_nxt_s;
    logic [WIDTH-1:0]       j_out_r;
    logic [WIDTH-1:0]       k_out_r;
    logic [ERR_CNT_W-1:0]   err_count_r;
    logic [ERR_CNT_W-1:0]   err_count_nxt_s;
    logic                   tgt_ready_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   accept_s;
    logic                   mismatch_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit #(
            .PREFER_TOGGLE (PREFER_TOGGLE)
        ) u_excite (
            .s (shadow_r[i]),
            .t (tgt_data[i]),
            .j (exc_j_s[i]),
            .k (exc_k_s[i])
        );
    end

    assign accept_s   = tgt_valid && tgt_ready_r;
    assign mismatch_s = (q_in != expected_r);

    // Next state plus the J/K code to present next cycle; outside DRIVE that is the hold code.
    always_comb begin
        state_nxt_s     = state_r;
        shadow_nxt_s    = shadow_r;
        expected_nxt_s  = expected_r;
        err_count_nxt_s = err_count_r;
        j_nxt_s         = shadow_r;
        k_nxt_s         = ZERO_W;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s    = DRIVE;
                    expected_nxt_s = tgt_data;
                    j_nxt_s        = exc_j_s;
                    k_nxt_s        = exc_k_s;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            DRIVE: begin
                state_nxt_s = CHECK;
                j_nxt_s     = expected_r;
            end
            CHECK: begin
                state_nxt_s = IDLE;
                if (mismatch_s) begin
                    shadow_nxt_s = q_in;
                    j_nxt_s      = q_in;
                    if (err_count_r != CNT_MAX) begin
                        err_count_nxt_s = err_count_r + CNT_ONE;
                    end else begin
                        err_count_nxt_s = err_count_r;
                    end
                end else begin
                    shadow_nxt_s = expected_r;
                    j_nxt_s      = expected_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, shadow and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            shadow_r    <= ZERO_W;
            expected_r  <= ZERO_W;
            err_count_r <= {ERR_CNT_W{1'b0}};
            j_out_r     <= ZERO_W;
            k_out_r     <= ZERO_W;
            tgt_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shadow_r    <= shadow_nxt_s;
            expected_r  <= expected_nxt_s;
            err_count_r <= err_count_nxt_s;
            j_out_r     <= j_nxt_s;
            k_out_r     <= k_nxt_s;
            tgt_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == CHECK);
        end
    end

    // The readback is only valid during CHECK itself, so the error flag qualifies the
    // registered done with the live compare; reset suppresses both.
    assign done      = done_r && !reset;
    assign err_pulse = done_r && !reset && mismatch_s;
    assign tgt_ready = tgt_ready_r;
    assign busy      = busy_r;
    assign j_out     = j_out_r;
    assign k_out     = k_out_r;
    assign err_count = err_count_r;

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Driving end of the team's synchronous JK flip-flop cell.
- Accepts target words over a valid/ready handshake and converts each one into per-bit J/K excitation vectors for an external bank of WIDTH JK cells.
- Holds a shadow copy of the bank state, reads back the bank outputs, and flags and counts any mismatch against the expected state.
- Sits between control logic and a JK register bank; it is the "write side" that makes the bank follow a requested sequence.

Parameters:
- WIDTH, 8, number of JK cells in the driven bank.
- PREFER_TOGGLE, 0, when 1 a changing bit is driven with J=1,K=1 (toggle); when 0 it is driven with a set/clear code.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- tgt_valid  in  1  target word offered.
- tgt_data  in  WIDTH  requested next bank state.
- tgt_ready  out  1  driver can accept a target this cycle.
- j_out  out  WIDTH  J inputs to the bank, registered.
- k_out  out  WIDTH  K inputs to the bank, registered.
- q_in  in  WIDTH  bank Q outputs, read back.
- busy  out  1  high in DRIVE and CHECK.
- done  out  1  one-cycle pulse in the cycle CHECK completes.
- err_pulse  out  1  one-cycle pulse on readback mismatch; coincident with done.
- err_count  out  ERR_CNT_W  saturating mismatch count.

Behaviour:
- Cell semantics being driven, per bit on the clock edge:
  - JK=00 gives Q=0.
  - JK=01 gives Q=0.
  - JK=10 gives Q=1.
  - JK=11 toggles Q.
  - JK=00 does NOT hold, so holding a 1 requires JK=10.
- Reset, synchronous: state=IDLE; shadow=0; j_out=0; k_out=0; tgt_ready=0 in the reset cycle; busy=0; done=0; err_pulse=0; err_count=0.
- Hold code, used whenever not in DRIVE: j_out=shadow, k_out=0. This preserves every bit of the bank.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&&tgt_ready: latch expected=tgt_data, register the excitation into j_out/k_out, go to DRIVE.
- Excitation per bit (s=shadow, t=target):
  - t=0: JK=01.
  - s=0,t=1: JK=10, or 11 if PREFER_TOGGLE.
  - s=1,t=1: JK=10.
  - s=1,t=0: JK=01, or 11 if PREFER_TOGGLE.
- DRIVE (exactly one cycle):
  - j_out/k_out present the excitation; the bank samples it at the end of this cycle.
  - Next cycle, j_out/k_out return to the hold code computed from expected.
  - Go to CHECK.
- CHECK (one cycle):
  - Compare q_in with expected.
  - Assert done.
  - On mismatch: err_pulse=1, err_count+=1 saturating at all-ones, and shadow:=q_in (resync to the actual bank).
  - On match: shadow:=expected.
  - Go to IDLE.
  - The hold code from the next cycle onward uses the updated shadow.
- Latency: accept at cycle T → excitation on j_out/k_out at T+1 → bank updates at the T+1/T+2 edge → done/err_pulse at T+2 → tgt_ready again at T+3. Throughput is one target per 3 cycles.
- tgt_ready=0 in DRIVE and CHECK. tgt_valid during those states is ignored, and the data must be held by the sender.
- A target equal to shadow is still processed; it produces the hold/set codes and a check.
- Reset mid-operation (DRIVE or CHECK): the transaction is abandoned, the outputs take their reset values, and no done or err_pulse is produced.
- err_count never wraps.

Decomposition:
- Shared package jk_pkg:
  - State enum {IDLE, DRIVE, CHECK}.
  - JK code constants JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - Per-bit excitation function (s, t, prefer_toggle) → {j,k}.
- Single natural sub-module: jk_excite_bit, the combinational per-bit excitation, instantiated WIDTH times via generate. Everything else stays in the top.
- The bench instantiates WIDTH of the team's JK cells as the bank.

Test Plan:
- Reset then idle for 5 cycles → j_out=0x00, k_out=0x00, err_count=0, tgt_ready=1 from the cycle after reset deasserts.
- WIDTH=8, PREFER_TOGGLE=0, target 0xA5 from 0x00 → j_out=0xA5 and k_out=0x5A at T+1; q=0xA5 and done at T+2; no err_pulse; hold j_out=0xA5, k_out=0x00 afterwards.
- PREFER_TOGGLE=1, shadow 0xA5, target 0x5A → j_out=0xFF, k_out=0xFF in DRIVE; q=0x5A at check; no error.
- Same target 0x3C twice → second transaction uses JK=10 on set bits and 01 on clear bits; q stays 0x3C; done pulses twice, 3 cycles apart minimum.
- Bench forces bank bit 0 stuck at 0, target 0x01 → err_pulse=1 with done; err_count=1; shadow=0x00, so the hold code is j_out=0x00.
- Assert reset in the DRIVE cycle → no done; all outputs at reset values the next cycle. Force 300 mismatches with ERR_CNT_W=8 → err_count saturates at 255.
